// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous sample FIFO with overflow accounting and optional pattern checker
// Optional feature: SAMPLE_FIFO_SEQ_CHECK_EN builds the generator pattern checker behind seq_err_cnt.
module sample_fifo #(
  parameter int DW = 16,
  parameter int AW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic [CW-1:0] drop_cnt,
  output logic [CW-1:0] seq_err_cnt
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_rd;
  logic          do_wr;
  logic          drop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A full FIFO still takes a write when a pop frees a slot on the same edge.
  always_comb begin
    do_rd = rd & ~empty;
    do_wr = wr & (~full | do_rd);
    drop  = wr & ~do_wr;
  end

  always_ff @(posedge clk) begin
    if (!rst && do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      dout_valid <= do_rd;
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SAMPLE_FIFO_SEQ_CHECK_EN
  logic [7:0]    prev;
  logic          seeded;
  logic [CW-1:0] seq_cnt;
  logic          seq_err;

  // The first strobe after reset has no predecessor, so only byte equality is checked.
  always_comb begin
    seq_err = (din[15:8] != din[7:0]) || (seeded && (din[7:0] != prev + 8'd1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= '0;
      seeded  <= 1'b0;
      seq_cnt <= '0;
    end else if (wr) begin
      prev   <= din[7:0];
      seeded <= 1'b1;
      if (seq_err && seq_cnt != '1) begin
        seq_cnt <= seq_cnt + 1'b1;
      end
    end
  end

  assign seq_err_cnt = seq_cnt;
`else
  assign seq_err_cnt = '0;
`endif

endmodule

// File: tb/tb_sample_fifo.sv
// tb/tb_sample_fifo.sv - self-checking bench for sample_fifo with a pop scoreboard
module tb_sample_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] din = '0;
  logic        rd = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        ovf;
  logic [15:0] drop_cnt;
  logic [15:0] seq_err_cnt;

  int tests = 0;
  int fails = 0;

  logic [15:0] model[$];
  logic [15:0] exp_q[$];
  logic        exp_dv = 1'b0;
  logic        exp_ovf = 1'b0;
  logic [15:0] exp_drop = '0;
  logic        mon_en = 1'b0;

  sample_fifo #(.DW(16), .AW(4), .CW(16)) dut (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd),
    .dout(dout), .dout_valid(dout_valid), .empty(empty), .full(full),
    .count(count), .ovf(ovf), .drop_cnt(drop_cnt), .seq_err_cnt(seq_err_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard drain: every dout_valid pulse must match the oldest expected pop.
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (dout_valid !== exp_dv) begin
        fails++;
        $display("FAIL dout_valid: got %b expected %b at %0t", dout_valid, exp_dv, $time);
      end
      if (dout_valid === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL pop_unexpected: got dout %h with no pop pending", dout);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (dout !== e) begin
            fails++;
            $display("FAIL pop_data: got %h expected %h", dout, e);
          end
        end
      end
    end
  end

  task automatic cycle(input logic w, input logic [15:0] d, input logic r);
    bit do_r;
    bit do_w;
    wr = w; din = d; rd = r;
    do_r = r && (model.size() > 0);
    do_w = w && ((model.size() < DEPTH) || do_r);
    if (do_r) exp_q.push_back(model.pop_front());
    if (do_w) model.push_back(d);
    if (w && !do_w) begin
      exp_ovf = 1'b1;
      if (exp_drop != 16'hFFFF) exp_drop++;
    end
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    exp_dv = do_r;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    exp_dv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model.delete(); exp_q.delete();
    exp_ovf = 1'b0; exp_drop = '0;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({empty, full, count, ovf, drop_cnt, seq_err_cnt, dout, dout_valid} !==
        {1'b1, 1'b0, 5'd0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: empty=%b full=%b count=%0d ovf=%b drop=%0d seq=%0d dout=%h dv=%b",
               empty, full, count, ovf, drop_cnt, seq_err_cnt, dout, dout_valid);
    end
  endtask

  task automatic test_order();
    logic [15:0] held;
    do_reset();
    for (int i = 1; i <= 5; i++) cycle(1'b1, {i[7:0], i[7:0]}, 1'b0);
    tests++;
    if (count !== 5'd5) begin fails++; $display("FAIL order_count: got %0d expected 5", count); end
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0, 1'b1);
    tests++;
    if (empty !== 1'b1) begin fails++; $display("FAIL order_empty: got %b expected 1", empty); end
    cycle(1'b0, 16'h0, 1'b0);
    held = 16'h0505;
    cycle(1'b0, 16'h0, 1'b1);
    tests++;
    if (dout !== held) begin fails++; $display("FAIL dout_hold: got %h expected %h", dout, held); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 16'h1000 + 16'(i), 1'b0);
    tests++;
    if (full !== 1'b1 || count !== 5'd16) begin
      fails++; $display("FAIL fill_full: got full=%b count=%0d expected full=1 count=16", full, count);
    end
    tests++;
    if (ovf !== exp_ovf || drop_cnt !== exp_drop || drop_cnt !== 16'd4) begin
      fails++; $display("FAIL overflow: got ovf=%b drop=%0d expected ovf=1 drop=4", ovf, drop_cnt);
    end
    for (int i = 0; i < 16; i++) cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0);
    tests++;
    if (empty !== 1'b1 || ovf !== 1'b1) begin
      fails++; $display("FAIL fill_drain: got empty=%b ovf=%b expected 1 1", empty, ovf);
    end
  endtask

  task automatic test_simul_full();
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'h2000 + 16'(i), 1'b0);
    cycle(1'b1, 16'h2ABC, 1'b1);
    tests++;
    if (count !== 5'd16 || drop_cnt !== 16'd0 || ovf !== 1'b0) begin
      fails++; $display("FAIL simul_full: got count=%0d drop=%0d ovf=%b expected 16 0 0", count, drop_cnt, ovf);
    end
    for (int i = 0; i < 16; i++) cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_simul_empty();
    do_reset();
    cycle(1'b1, 16'h3C3C, 1'b1);
    tests++;
    if (count !== 5'd1 || dout_valid !== 1'b0) begin
      fails++; $display("FAIL simul_empty: got count=%0d dv=%b expected 1 0", count, dout_valid);
    end
    cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_wrap();
    int maxc;
    do_reset();
    maxc = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 16'($urandom), 1'b0);
      if (int'(count) > maxc) maxc = int'(count);
      cycle(1'b0, 16'h0, 1'b1);
      if (int'(count) > maxc) maxc = int'(count);
    end
    cycle(1'b0, 16'h0, 1'b0);
    tests++;
    if (maxc !== 1 || empty !== 1'b1) begin
      fails++; $display("FAIL wrap_count: got max=%0d empty=%b expected 1 1", maxc, empty);
    end
  endtask

  task automatic test_seq();
    logic [15:0] stream [5];
    logic [15:0] exp_seq;
    stream[0] = 16'hFEFE; stream[1] = 16'hFFFF; stream[2] = 16'h0000;
    stream[3] = 16'h0202; stream[4] = 16'h0304;
`ifdef SAMPLE_FIFO_SEQ_CHECK_EN
    exp_seq = 16'd2;
`else
    exp_seq = 16'd0;
`endif
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, stream[i], 1'b0);
    tests++;
    if (seq_err_cnt !== exp_seq) begin
      fails++; $display("FAIL seq_err_cnt: got %0d expected %0d", seq_err_cnt, exp_seq);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_order();
    test_fill_overflow();
    test_simul_full();
    test_simul_empty();
    test_wrap();
    test_seq();
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_leftover: got %0d pending pops expected 0", exp_q.size());
    end
    test_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
